instr_rd_arbiter: RTL and testbench

Two-requester AXI3 read-channel arbiter that shares one instruction-side AXI read port between the icache refill engine (requester 0) and the icache prefetcher (requester 1). It sits between the `axi` refill master and the `pre_fetch` master on one side and the single `instr_*` AXI bus on the other, so the core exposes one instruction read port instead of two. Only one 8-beat burst is outstanding at a time; refill has priority, and a starvation counter bounds prefetch wait.

---
 rtl/instr_rd_arbiter.sv | 155 +++++++++++++++
 tb/tb_instr_rd_arbiter.sv | 470 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_rd_arbiter.sv
// Instruction-side AXI3 read arbiter: refill (m0) vs prefetch (m1).
// One burst in flight; refill wins unless prefetch has starved too long.
module instr_rd_arbiter #(
  parameter int BURST_LEN  = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        m0_arvalid,
  input  logic [31:0] m0_araddr,
  output logic        m0_arready,
  output logic [31:0] m0_rdata,
  output logic        m0_rvalid,
  output logic        m0_rlast,
  input  logic        m0_rready,
  input  logic        m1_arvalid,
  input  logic [31:0] m1_araddr,
  output logic        m1_arready,
  output logic [31:0] m1_rdata,
  output logic        m1_rvalid,
  output logic        m1_rlast,
  input  logic        m1_rready,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic        grant,
  output logic        busy,
  output logic        rd_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_RD
  } state_t;

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
  localparam logic [2:0] LAST_BEAT = 3'(BURST_LEN - 1);

  state_t        r_state;
  logic          r_grant;
  logic [SW-1:0] r_starve;
  logic [2:0]    r_beat;
  logic [31:0]   r_addr;
  logic          r_err;

  logic w_req;
  logic w_pick1;
  logic w_addr;
  logic w_rd;
  logic w_sel0;
  logic w_sel1;
  logic w_rready;
  logic w_xfer;
  logic w_bad;

  assign w_req   = m0_arvalid | m1_arvalid;
  assign w_pick1 = m1_arvalid &
                   (~m0_arvalid | (r_starve == SMAX));
  assign w_addr  = (r_state == S_ADDR);
  assign w_rd    = (r_state == S_RD);
  assign w_sel0  = w_rd & ~r_grant;
  assign w_sel1  = w_rd & r_grant;

  assign w_rready = (w_sel0 & m0_rready) |
                    (w_sel1 & m1_rready);
  assign w_xfer   = w_rready & rvalid;

  // A missing or early rlast is judged against the beat index.
  assign w_bad = (rresp != 2'b00) |
                 (rid != {3'b000, r_grant}) |
                 (rlast & (r_beat != LAST_BEAT)) |
                 (~rlast & (r_beat == LAST_BEAT));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state  <= S_IDLE;
      r_grant  <= 1'b0;
      r_starve <= '0;
      r_beat   <= 3'd0;
      r_addr   <= 32'd0;
      r_err    <= 1'b0;
    end else begin
      r_err <= w_xfer & w_bad;
      unique case (r_state)
        S_IDLE: begin
          if (!m1_arvalid)
            r_starve <= '0;
          if (w_req) begin
            r_grant <= w_pick1;
            r_addr  <= w_pick1 ? m1_araddr : m0_araddr;
            r_beat  <= 3'd0;
            r_state <= S_ADDR;
            if (w_pick1)
              r_starve <= '0;
            else if (m1_arvalid && r_starve != SMAX)
              r_starve <= r_starve + 1'b1;
          end
        end
        S_ADDR: begin
          if (arready)
            r_state <= S_RD;
        end
        S_RD: begin
          if (w_xfer) begin
            r_beat <= r_beat + 3'd1;
            if (rlast)
              r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign arvalid = w_addr;
  assign araddr  = r_addr;
  assign arid    = {3'b000, r_grant};
  assign arlen   = 4'(BURST_LEN - 1);
  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;

  assign m0_arready = w_addr & arready & ~r_grant;
  assign m1_arready = w_addr & arready & r_grant;

  assign m0_rvalid = w_sel0 & rvalid;
  assign m1_rvalid = w_sel1 & rvalid;
  assign m0_rlast  = w_sel0 & rlast;
  assign m1_rlast  = w_sel1 & rlast;
  assign m0_rdata  = w_sel0 ? rdata : 32'd0;
  assign m1_rdata  = w_sel1 ? rdata : 32'd0;

  assign rready = w_rready;
  assign grant  = r_grant;
  assign busy   = (r_state != S_IDLE);
  assign rd_err = r_err;

endmodule

// File: tb/tb_instr_rd_arbiter.sv
// Scoreboard bench for instr_rd_arbiter: random bursts, errors,
// backpressure, starvation and mid-burst reset.
module tb_instr_rd_arbiter;

  localparam int BL = 8;
  localparam int SM = 4;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        m0_arvalid, m1_arvalid;
  logic [31:0] m0_araddr, m1_araddr;
  logic        m0_arready, m1_arready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_rvalid, m1_rvalid;
  logic        m0_rlast, m1_rlast;
  logic        m0_rready, m1_rready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic        grant;
  logic        busy;
  logic        rd_err;

  always #5 aclk = ~aclk;

  instr_rd_arbiter #(
    .BURST_LEN (BL),
    .STARVE_MAX(SM)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .m0_arvalid(m0_arvalid),
    .m0_araddr (m0_araddr),
    .m0_arready(m0_arready),
    .m0_rdata  (m0_rdata),
    .m0_rvalid (m0_rvalid),
    .m0_rlast  (m0_rlast),
    .m0_rready (m0_rready),
    .m1_arvalid(m1_arvalid),
    .m1_araddr (m1_araddr),
    .m1_arready(m1_arready),
    .m1_rdata  (m1_rdata),
    .m1_rvalid (m1_rvalid),
    .m1_rlast  (m1_rlast),
    .m1_rready (m1_rready),
    .arid      (arid),
    .araddr    (araddr),
    .arlen     (arlen),
    .arsize    (arsize),
    .arburst   (arburst),
    .arlock    (arlock),
    .arcache   (arcache),
    .arprot    (arprot),
    .arvalid   (arvalid),
    .arready   (arready),
    .rid       (rid),
    .rdata     (rdata),
    .rresp     (rresp),
    .rlast     (rlast),
    .rvalid    (rvalid),
    .rready    (rready),
    .grant     (grant),
    .busy      (busy),
    .rd_err    (rd_err)
  );

  typedef struct {
    logic [31:0] data;
    bit          last;
    bit          err;
  } beat_t;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
  } ar_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    bit          badid;
    bit          last;
  } sb_t;

  beat_t       eb0[$];
  beat_t       eb1[$];
  ar_t         ear[$];
  logic [31:0] rq0[$];
  logic [31:0] rq1[$];
  sb_t         tbl[256][10];
  int          tbl_n[256];
  int          nburst = 0;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          stall_min = 0;
  bit          abort = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Burst n lives at address bits [13:6] so the slave can find it.
  task automatic mk_req(input bit who, input int mode,
                        input int k, output logic [31:0] a);
    int    n;
    int    nb;
    sb_t   s;
    beat_t b;
    n = nburst;
    nburst++;
    a = (n == 0) ? 32'h1FC0_0020 :
        {18'($urandom), 8'(n), 6'b0};
    nb = (mode == 3) ? k + 1 : (mode == 4) ? BL + 1 : BL;
    tbl_n[n] = nb;
    for (int i = 0; i < nb; i++) begin
      s.data  = (n == 0) ? 32'(i) : $urandom;
      s.resp  = (mode == 1 && i == k) ?
                2'($urandom_range(1, 3)) : 2'b00;
      s.badid = (mode == 2 && i == k);
      s.last  = (i == nb - 1);
      tbl[n][i] = s;
      b.data = s.data;
      b.last = s.last;
      b.err  = (s.resp != 0) || s.badid ||
               (s.last && i != BL - 1) ||
               (!s.last && i == BL - 1);
      if (who) eb1.push_back(b);
      else eb0.push_back(b);
    end
    if (who) rq1.push_back(a);
    else rq0.push_back(a);
  endtask

  task automatic run_phase(input int c0, input int c1,
                           input int mode, input int k);
    logic [31:0] a0[$];
    logic [31:0] a1[$];
    logic [31:0] a;
    int          m;
    int          kk;
    int          cnt;
    int          t;
    if (abort) return;
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < (w == 0 ? c0 : c1); i++) begin
        m  = mode;
        kk = k;
        if (mode < 0) begin
          m  = int'($urandom % 8);
          m  = (m < 4) ? m + 1 : 0;
          kk = (m == 3) ? int'($urandom % 7) :
                          int'($urandom % 8);
        end
        mk_req(w[0], m, kk, a);
        if (w == 0) a0.push_back(a);
        else a1.push_back(a);
      end
    end
    // Both requesters hold their queues continuously from now on.
    cnt = 0;
    while (a0.size() != 0 || a1.size() != 0) begin
      if (a0.size() != 0 && !(a1.size() != 0 && cnt == SM)) begin
        ear.push_back('{4'd0, a0.pop_front()});
        cnt = (a1.size() == 0) ? 0 : (cnt < SM ? cnt + 1 : cnt);
      end else begin
        ear.push_back('{4'd1, a1.pop_front()});
        cnt = 0;
      end
    end
    t = 0;
    do begin
      @(negedge aclk);
      #1;
      t++;
    end while (t < 4000 &&
               (rq0.size() != 0 || rq1.size() != 0 ||
                eb0.size() != 0 || eb1.size() != 0 ||
                ear.size() != 0 || busy));
    chk("drain_timeout", 32'(t < 4000), 32'd1);
    if (t >= 4000) abort = 1;
    repeat (3) @(negedge aclk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_arvalid"}, 32'(arvalid), 32'd0);
    chk({tag, "_rready"}, 32'(rready), 32'd0);
    chk({tag, "_m0_arready"}, 32'(m0_arready), 32'd0);
    chk({tag, "_m1_arready"}, 32'(m1_arready), 32'd0);
    chk({tag, "_m0_rvalid"}, 32'(m0_rvalid), 32'd0);
    chk({tag, "_m1_rvalid"}, 32'(m1_rvalid), 32'd0);
    chk({tag, "_m0_rlast"}, 32'(m0_rlast), 32'd0);
    chk({tag, "_m1_rlast"}, 32'(m1_rlast), 32'd0);
    chk({tag, "_m0_rdata"}, m0_rdata, 32'd0);
    chk({tag, "_m1_rdata"}, m1_rdata, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_rd_err"}, 32'(rd_err), 32'd0);
    chk({tag, "_araddr"}, araddr, 32'd0);
    chk({tag, "_grant"}, 32'(grant), 32'd0);
    chk({tag, "_arid"}, 32'(arid), 32'd0);
  endtask

  initial begin : req0_p
    m0_arvalid = 1'b0;
    m0_araddr  = 32'd0;
    m0_rready  = 1'b0;
    forever begin
      @(negedge aclk);
      if (aresetn && m0_arvalid && m0_arready)
        void'(rq0.pop_front());
      @(posedge aclk);
      #1;
      m0_arvalid = aresetn && (rq0.size() != 0);
      if (m0_arvalid) m0_araddr = rq0[0];
      m0_rready = ($urandom % 4) != 0;
    end
  end

  initial begin : req1_p
    m1_arvalid = 1'b0;
    m1_araddr  = 32'd0;
    m1_rready  = 1'b0;
    forever begin
      @(negedge aclk);
      if (aresetn && m1_arvalid && m1_arready)
        void'(rq1.pop_front());
      @(posedge aclk);
      #1;
      m1_arvalid = aresetn && (rq1.size() != 0);
      if (m1_arvalid) m1_araddr = rq1[0];
      m1_rready = ($urandom % 3) != 0;
    end
  end

  bit         s_act = 0;
  bit         s_took = 0;
  int         s_cur = 0;
  int         s_idx = 0;
  int         s_wait = 0;
  int         s_tgt = 0;
  logic [3:0] s_cid = 4'd0;

  initial begin : slave_p
    arready = 1'b0;
    rvalid  = 1'b0;
    rdata   = 32'd0;
    rresp   = 2'b00;
    rid     = 4'd0;
    rlast   = 1'b0;
    forever begin
      @(negedge aclk);
      s_took = aresetn && rvalid && rready;
      if (s_took) begin
        s_idx++;
        if (s_idx >= tbl_n[s_cur]) s_act = 0;
      end
      if (aresetn && arvalid && arready) begin
        s_act = 1;
        s_cur = int'(araddr[13:6]);
        s_cid = arid;
        s_idx = 0;
      end
      @(posedge aclk);
      #1;
      if (!aresetn) begin
        s_act   = 0;
        s_wait  = 0;
        arready = 1'b0;
        rvalid  = 1'b0;
        rlast   = 1'b0;
      end else begin
        if (!arvalid) begin
          arready = 1'b0;
          s_wait  = 0;
          s_tgt   = stall_min + int'($urandom % 3);
        end else begin
          arready = (s_wait >= s_tgt);
          s_wait++;
        end
        if (!s_act) begin
          rvalid = 1'b0;
          rlast  = 1'b0;
        end else if (!rvalid || s_took) begin
          rvalid = ($urandom % 4) != 0;
          rdata  = tbl[s_cur][s_idx].data;
          rresp  = tbl[s_cur][s_idx].resp;
          rid    = s_cid ^ {3'b000, tbl[s_cur][s_idx].badid};
          rlast  = rvalid && tbl[s_cur][s_idx].last;
        end
      end
    end
  end

  bit          mon_idle = 1;
  bit          mon_exp_av = 0;
  bit          mon_rd = 0;
  bit          mon_pend = 0;
  bit          mon_g = 0;
  bit          mon_err = 0;
  logic [31:0] mon_pa = 32'd0;

  initial begin : monitor_p
    bit    idle_now;
    bit    nerr;
    bit    sel0;
    bit    sel1;
    bit    grr;
    beat_t b;
    ar_t   e;
    forever begin
      @(negedge aclk);
      cyc++;
      if (!aresetn) begin
        mon_idle   = 1;
        mon_exp_av = 0;
        mon_rd     = 0;
        mon_pend   = 0;
        mon_err    = 0;
      end else begin
        idle_now = mon_idle;
        nerr     = 0;
        chk("rd_err", 32'(rd_err), 32'(mon_err));
        chk("busy", 32'(busy), 32'(!idle_now));
        if (mon_exp_av) begin
          chk("ar_latency", 32'(arvalid), 32'd1);
          mon_exp_av = 0;
        end else if (idle_now) begin
          chk("idle_arvalid", 32'(arvalid), 32'd0);
        end
        if (idle_now && (m0_arvalid || m1_arvalid)) begin
          mon_exp_av = 1;
          mon_idle   = 0;
        end
        if (mon_pend) begin
          chk("ar_hold_valid", 32'(arvalid), 32'd1);
          chk("ar_hold_addr", araddr, mon_pa);
        end
        sel0 = mon_rd && !mon_g;
        sel1 = mon_rd && mon_g;
        grr  = mon_g ? m1_rready : m0_rready;
        chk("rready", 32'(rready), 32'(mon_rd && grr));
        chk("m0_rvalid", 32'(m0_rvalid), 32'(sel0 && rvalid));
        chk("m1_rvalid", 32'(m1_rvalid), 32'(sel1 && rvalid));
        chk("m0_rdata", m0_rdata, sel0 ? rdata : 32'd0);
        chk("m1_rdata", m1_rdata, sel1 ? rdata : 32'd0);
        if (mon_rd) chk("grant", 32'(grant), 32'(mon_g));
        if (m0_rvalid && m0_rready) begin
          if (eb0.size() == 0) begin
            chk("m0_extra_beat", 32'd1, 32'd0);
          end else begin
            b = eb0.pop_front();
            chk("m0_beat_data", m0_rdata, b.data);
            chk("m0_beat_last", 32'(m0_rlast), 32'(b.last));
            nerr = b.err;
          end
        end
        if (m1_rvalid && m1_rready) begin
          if (eb1.size() == 0) begin
            chk("m1_extra_beat", 32'd1, 32'd0);
          end else begin
            b = eb1.pop_front();
            chk("m1_beat_data", m1_rdata, b.data);
            chk("m1_beat_last", 32'(m1_rlast), 32'(b.last));
            nerr = b.err;
          end
        end
        if (mon_rd && rvalid && grr && rlast) begin
          mon_rd   = 0;
          mon_idle = 1;
        end
        mon_pend = 0;
        if (arvalid && arready) begin
          if (ear.size() == 0) begin
            chk("ar_unexpected", 32'd1, 32'd0);
            mon_g = 0;
          end else begin
            e = ear.pop_front();
            chk("arid", 32'(arid), 32'(e.id));
            chk("araddr", araddr, e.addr);
            chk("arlen", 32'(arlen), 32'(BL - 1));
            chk("arsize", 32'(arsize), 32'd2);
            chk("arburst", 32'(arburst), 32'd1);
            chk("ar_misc", 32'({arlock, arcache, arprot}), 32'd0);
            mon_g = e.id[0];
          end
          mon_rd = 1;
        end else if (arvalid) begin
          mon_pend = 1;
          mon_pa   = araddr;
        end
        mon_err = nerr;
      end
    end
  end

  initial begin : main_p
    logic [31:0] a;
    int          t;
    aresetn = 1'b0;
    #2;
    chk_reset("rst0");
    repeat (3) @(negedge aclk);
    #1;
    aresetn = 1'b1;
    @(negedge aclk);
    #1;
    run_phase(1, 0, 0, 0);
    run_phase(1, 1, 0, 0);
    run_phase(6, 2, 0, 0);
    stall_min = 5;
    run_phase(2, 1, 0, 0);
    stall_min = 0;
    run_phase(1, 0, 1, 2);
    run_phase(1, 0, 3, 5);
    run_phase(1, 0, 2, 4);
    run_phase(0, 1, 4, 0);
    run_phase(2, 2, 3, 0);
    for (int r = 0; r < 10; r++)
      run_phase(int'($urandom % 6), int'($urandom % 6), -1, 0);
    if (!abort) begin
      mk_req(1'b0, 0, 0, a);
      ear.push_back('{4'd0, a});
      t = 0;
      do begin
        @(negedge aclk);
        #1;
        t++;
      end while (t < 500 && eb0.size() > BL - 4);
      chk("rst_wait", 32'(eb0.size()), 32'(BL - 4));
      aresetn = 1'b0;
      #1;
      chk_reset("rst_mid");
      rq0.delete();
      rq1.delete();
      eb0.delete();
      eb1.delete();
      ear.delete();
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      #1;
      aresetn = 1'b1;
      run_phase(0, 1, 0, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
